// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and helpers for the multiplexed 7-segment scanner.
//   state_e  : per-slot phase, BLANK (all anodes off) then DRIVE
//   SEG_OFF  : inactive level for the active-low anode and decimal-point lines
//   clog2    : index/counter width helper (minimum 1 bit)
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic SEG_OFF = 1'b1;

  // Smallest width able to hold 0..v-1; never returns 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i) + 32'd1;
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bus between a display client and the scanner.
//   master : drives value/load/dp_in/digit_en, observes display outputs
//   slave  : the scanner; drives nibble/an/dp/frame_done
//   value      4*N_DIGITS  hex value, digit 0 in value[3:0]
//   load       1           one-cycle capture strobe
//   dp_in      N_DIGITS    decimal point request per digit, active-high
//   digit_en   N_DIGITS    per-digit enable
//   nibble     4           digit code for the seg7 decoder
//   an         N_DIGITS    anode selects, active-low
//   dp         1           decimal point, active-low
//   frame_done 1           one-cycle pulse at each frame boundary
interface seg7_scan_if #(
  parameter int unsigned N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] value;
  logic                  load;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic [3:0]            nibble;
  logic [N_DIGITS-1:0]   an;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output value, load, dp_in, digit_en,
    input  nibble, an, dp, frame_done
  );

  modport slave (
    input  value, load, dp_in, digit_en,
    output nibble, an, dp, frame_done
  );

endinterface

// File: rtl/seg7_refresh_tick.sv
// seg7_refresh_tick: per-slot cycle counter for the display scanner.
//   clk, rst        clock and asynchronous active-high reset
//   o_slot_start_c  high in the last cycle of a slot; the following edge starts a new slot
//   o_blank_end_c   high in the last BLANK cycle; the following edge enters DRIVE
// Assumes 1 <= BLANK_CYC and REFRESH_DIV >= BLANK_CYC + 2.
module seg7_refresh_tick
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic clk,
  input  logic rst,
  output logic o_slot_start_c,
  output logic o_blank_end_c
);

  localparam int unsigned CNT_W = clog2(REFRESH_DIV);

  logic [CNT_W-1:0] r_cnt;

  // Slot counter 0..REFRESH_DIV-1, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_slot_start_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_slot_start_c = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign o_blank_end_c  = (r_cnt == CNT_W'(BLANK_CYC - 1));

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed scanner for an N-digit common-anode 7-segment display.
//   clk, rst  clock and asynchronous active-high reset
//   bus       seg7_scan_if slave: value/load/dp_in/digit_en in; nibble/an/dp/frame_done out
// Each digit slot is BLANK_CYC cycles with all anodes off, then driven until the slot
// ends. Loaded values sit in a pending copy and reach the display copy only at a frame
// boundary, so a frame never mixes two values.
// Optional: SEG7_LZ_SUPPRESS_EN blanks digits above the most significant nonzero nibble
// of the displayed value (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam int unsigned VAL_W = 4 * N_DIGITS;
  localparam int unsigned IDX_W = clog2(N_DIGITS);

  logic                w_slot_start;
  logic                w_blank_end;
  logic                w_frame_end;
  logic                w_show;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;

  logic [VAL_W-1:0]    r_pend_val;
  logic [N_DIGITS-1:0] r_pend_dp;
  logic [N_DIGITS-1:0] r_pend_en;
  logic [VAL_W-1:0]    r_disp_val;
  logic [N_DIGITS-1:0] r_disp_dp;
  logic [N_DIGITS-1:0] r_disp_en;
  logic [VAL_W-1:0]    w_disp_val_nxt;
  logic [N_DIGITS-1:0] w_disp_dp_nxt;
  logic [N_DIGITS-1:0] w_disp_en_nxt;

  logic [N_DIGITS-1:0] r_an;
  logic [N_DIGITS-1:0] w_an_nxt;
  logic                r_dp;
  logic                w_dp_nxt;
  logic [3:0]          r_nibble;
  logic [3:0]          w_nibble_nxt;
  logic                r_frame_done;

  seg7_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_tick (
    .clk            (clk),
    .rst            (rst),
    .o_slot_start_c (w_slot_start),
    .o_blank_end_c  (w_blank_end)
  );

  assign w_frame_end = w_slot_start && (r_idx == IDX_W'(N_DIGITS - 1));

  // Pending copy: last load wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_en  <= '1;
    end else if (bus.load) begin
      r_pend_val <= bus.value;
      r_pend_dp  <= bus.dp_in;
      r_pend_en  <= bus.digit_en;
    end
  end

  // Display copy refreshes only at a frame boundary; a load in that cycle bypasses pending.
  always_comb begin
    w_disp_val_nxt = r_disp_val;
    w_disp_dp_nxt  = r_disp_dp;
    w_disp_en_nxt  = r_disp_en;
    if (w_frame_end) begin
      if (bus.load) begin
        w_disp_val_nxt = bus.value;
        w_disp_dp_nxt  = bus.dp_in;
        w_disp_en_nxt  = bus.digit_en;
      end else begin
        w_disp_val_nxt = r_pend_val;
        w_disp_dp_nxt  = r_pend_dp;
        w_disp_en_nxt  = r_pend_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_val <= '0;
      r_disp_dp  <= '0;
      r_disp_en  <= '1;
    end else begin
      r_disp_val <= w_disp_val_nxt;
      r_disp_dp  <= w_disp_dp_nxt;
      r_disp_en  <= w_disp_en_nxt;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [IDX_W-1:0] w_msd;

  // Highest digit holding a nonzero nibble; 0 when the whole value is zero.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (r_disp_val[4*i +: 4] != 4'h0) w_msd = IDX_W'(i);
    end
  end

  assign w_show = (r_idx <= w_msd);
`else
  assign w_show = 1'b1;
`endif

  // State, slot index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BLANK;
      r_idx        <= '0;
      r_an         <= {N_DIGITS{SEG_OFF}};
      r_dp         <= SEG_OFF;
      r_nibble     <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_an         <= w_an_nxt;
      r_dp         <= w_dp_nxt;
      r_nibble     <= w_nibble_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_an_nxt     = {N_DIGITS{SEG_OFF}};
    w_dp_nxt     = SEG_OFF;
    w_nibble_nxt = r_nibble;

    if (w_slot_start) begin
      w_state_nxt = BLANK;
    end else begin
      case (r_state)
        BLANK:   if (w_blank_end) w_state_nxt = DRIVE;
        DRIVE:   w_state_nxt = DRIVE;
        default: w_state_nxt = BLANK;
      endcase
    end

    if (w_slot_start) begin
      w_idx_nxt = w_frame_end ? '0 : r_idx + IDX_W'(1);
      // Nibble is set once at slot start and held for the whole slot.
      for (int i = 0; i < N_DIGITS; i++) begin
        if (IDX_W'(i) == w_idx_nxt) w_nibble_nxt = w_disp_val_nxt[4*i +: 4];
      end
    end

    if (w_state_nxt == DRIVE && w_show) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (IDX_W'(i) == r_idx) begin
          w_an_nxt[i] = ~r_disp_en[i];
          w_dp_nxt    = ~r_disp_dp[i];
        end
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.dp         = r_dp;
  assign bus.nibble     = r_nibble;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: self-checking bench for seg7_scan (4 digits, 8-cycle slots, 2 blank cycles).
// A cycle-count model derives every expected output from the time since reset release
// and the values loaded so far; directed literal checks pin that model.
module tb_seg7_scan;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = N * RD;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  seg7_scan_if #(.N_DIGITS(N)) bus ();

  seg7_scan #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: cycles since reset release, pending and displayed contents.
  int         m_t    = 0;
  logic [15:0] m_pval = '0;
  logic [3:0]  m_pdp  = '0;
  logic [3:0]  m_pen  = '1;
  logic [15:0] m_dval = '0;
  logic [3:0]  m_ddp  = '0;
  logic [3:0]  m_den  = '1;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (time %0t, t=%0d)", nm, act, want, $time, m_t);
    end
  endtask

  function automatic int lz_msd(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 1; i < N; i++) begin
      if (((v >> (4 * i)) & 16'hF) != 16'h0) r = i;
    end
    return r;
  endfunction

  function automatic void expect_now(output logic [3:0] an, output logic dp,
                                     output logic [3:0] nib, output logic fd);
    int ph;
    int slot;
    bit shown;
    an  = 4'hF;
    dp  = 1'b1;
    nib = 4'h0;
    fd  = 1'b0;
    if (!rst) begin
      ph    = m_t % RD;
      slot  = (m_t / RD) % N;
      nib   = 4'((m_dval >> (4 * slot)) & 16'hF);
      fd    = (m_t > 0) && ((m_t % FRAME) == 0);
      shown = 1'b1;
`ifdef SEG7_LZ_SUPPRESS_EN
      shown = (slot <= lz_msd(m_dval));
`endif
      if (ph >= BC && shown) begin
        if (m_den[slot]) an = ~(4'b0001 << slot);
        dp = ~m_ddp[slot];
      end
    end
  endfunction

  // Model update on every active edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_t = 0;
      m_pval = '0; m_pdp = '0; m_pen = '1;
      m_dval = '0; m_ddp = '0; m_den = '1;
    end else begin
      if (bus.load) begin
        m_pval = bus.value;
        m_pdp  = bus.dp_in;
        m_pen  = bus.digit_en;
      end
      m_t++;
      if ((m_t % FRAME) == 0) begin
        m_dval = m_pval;
        m_ddp  = m_pdp;
        m_den  = m_pen;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic [3:0] e_an;
    logic       e_dp;
    logic [3:0] e_nib;
    logic       e_fd;
    @(posedge clk);
    forever begin
      @(negedge clk);
      expect_now(e_an, e_dp, e_nib, e_fd);
      chk("model_an", int'(bus.an), int'(e_an));
      chk("model_dp", int'(bus.dp), int'(e_dp));
      chk("model_nibble", int'(bus.nibble), int'(e_nib));
      chk("model_frame_done", int'(bus.frame_done), int'(e_fd));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_phase(input int ph);
    int k;
    k = 0;
    while (((m_t % FRAME) != ph) && (k < 2 * FRAME)) begin
      next_cycle();
      k++;
    end
    if (k >= 2 * FRAME) begin
      n_cmp++;
      n_bad++;
      $display("FAIL goto_phase: phase %0d not reached, at %0d", ph, m_t % FRAME);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bus.value    = v;
    bus.dp_in    = d;
    bus.digit_en = e;
    bus.load     = 1'b1;
    next_cycle();
    bus.load     = 1'b0;
  endtask

  task automatic chk_at(input string nm, input int ph, input logic [3:0] an,
                        input logic [3:0] nib, input logic fd);
    goto_phase(ph);
    @(negedge clk);
    chk({nm, "_an"}, int'(bus.an), int'(an));
    chk({nm, "_nibble"}, int'(bus.nibble), int'(nib));
    chk({nm, "_frame_done"}, int'(bus.frame_done), int'(fd));
    next_cycle();
  endtask

  // One frame from phase 0: which anodes went low, dp-low cycles, dp-low outside digit-1 DRIVE.
  task automatic scan_frame(output logic [3:0] drv, output int dp_lows, output int dp_out);
    drv = '0;
    dp_lows = 0;
    dp_out = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      drv = drv | ~bus.an;
      if (!bus.dp) begin
        dp_lows++;
        if (i < RD + BC || i >= 2 * RD) dp_out++;
      end
      next_cycle();
    end
  endtask

  initial begin
    logic [3:0] drv;
    int dpl;
    int dpo;
    int fd_cnt;
    int max_low;
    int lows;

    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.digit_en = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_an", int'(bus.an), 32'hF);
    chk("reset_dp", int'(bus.dp), 1);
    chk("reset_nibble", int'(bus.nibble), 0);
    chk("reset_frame_done", int'(bus.frame_done), 0);
    next_cycle();
    rst = 1'b0;

    // Load 1234, shown from the next frame
    goto_phase(5);
    do_load(16'h1234, 4'h0, 4'hF);
    chk_at("f1_d0_blank", 0, 4'b1111, 4'h4, 1'b1);
    chk_at("f1_d0_drive", 2, 4'b1110, 4'h4, 1'b0);
    chk_at("f1_d1_blank", 8, 4'b1111, 4'h3, 1'b0);
    chk_at("f1_d1_drive", 10, 4'b1101, 4'h3, 1'b0);

    // Mid-frame load does not tear the current frame
    goto_phase(12);
    do_load(16'hABCD, 4'h0, 4'hF);
    chk_at("f1_d2_drive", 18, 4'b1011, 4'h2, 1'b0);
    chk_at("f1_d3_drive", 26, 4'b0111, 4'h1, 1'b0);
    chk_at("f2_d0", 0, 4'b1111, 4'hD, 1'b1);
    chk_at("f2_d3", 26, 4'b0111, 4'hA, 1'b0);

    // Load in the boundary cycle takes effect in the frame it opens
    goto_phase(31);
    do_load(16'h5678, 4'h0, 4'hF);
    chk_at("bypass_d0", 0, 4'b1111, 4'h8, 1'b1);
    chk_at("bypass_d3", 24, 4'b1111, 4'h5, 1'b0);

    // Free run: one frame_done per 32 cycles, never two anodes low
    goto_phase(1);
    fd_cnt = 0;
    max_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_done) fd_cnt++;
      lows = $countones(~bus.an);
      if (lows > max_low) max_low = lows;
      next_cycle();
    end
    chk("freerun_frame_done_count", fd_cnt, 6);
    chk("freerun_max_anodes_low", max_low, 1);

    // Digit enables and decimal point
    do_load(16'h5678, 4'b0010, 4'b0101);
    goto_phase(0);
    scan_frame(drv, dpl, dpo);
    chk("en_driven_mask", int'(drv), 32'h5);
    chk("dp_low_cycles", dpl, 6);
    chk("dp_low_outside_d1_drive", dpo, 0);

    // Leading-zero behaviour
    do_load(16'h0042, 4'b1100, 4'hF);
    goto_phase(0);
    scan_frame(drv, dpl, dpo);
`ifdef SEG7_LZ_SUPPRESS_EN
    chk("lz_0042_mask", int'(drv), 32'h3);
    chk("lz_0042_dp_lows", dpl, 0);
`else
    chk("lz_0042_mask", int'(drv), 32'hF);
    chk("lz_0042_dp_lows", dpl, 12);
`endif
    do_load(16'h0000, 4'h0, 4'hF);
    goto_phase(0);
    scan_frame(drv, dpl, dpo);
`ifdef SEG7_LZ_SUPPRESS_EN
    chk("lz_0000_mask", int'(drv), 32'h1);
`else
    chk("lz_0000_mask", int'(drv), 32'hF);
`endif
    @(negedge clk);
    chk("lz_0000_nibble", int'(bus.nibble), 0);
    next_cycle();

    // Reset pulse mid-DRIVE clears outputs immediately and restarts at digit 0
    goto_phase(4);
    @(negedge clk);
    chk("pre_rst_an", int'(bus.an), 32'hE);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rst_async_an", int'(bus.an), 32'hF);
    chk("rst_async_dp", int'(bus.dp), 1);
    chk("rst_async_nibble", int'(bus.nibble), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_blank_an", int'(bus.an), 32'hF);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("post_rst_drive_an", int'(bus.an), 32'hE);
    chk("post_rst_nibble", int'(bus.nibble), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
